// File: rtl/buffer_r.sv
// buffer_r: receive-side UART FIFO. The receiver shift logic pushes bytes in
// and the CPU drains them through a 2-bit register address.
// Register map: 0 data (pop), 1 status, 2 fill count, 3 clear overflow.
// Status byte: bit0 rrxrdy, bit1 rFULL, bit2 rOVF, bit3 headFE.
// Optional build macro RX_FRAME_ERR_EN: stores the framing-error flag with each
// entry and reports the flag of the head entry in status bit 3.
module buffer_r #(
    parameter int BITWIDTH = 8,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2
) (
    input  logic                rClk,
    input  logic                rRst,
    input  logic                rWR,
    input  logic [BITWIDTH-1:0] rdataIn,
    input  logic                rFE,
    input  logic                rRD,
    input  logic [1:0]          rpaddr,
    output logic [BITWIDTH-1:0] rdataOut,
    output logic                rEMPTY,
    output logic                rFULL,
    output logic                rrxrdy,
    output logic                rOVF
);

`ifdef RX_FRAME_ERR_EN
    localparam int ENTRY_W = BITWIDTH + 1;
`else
    localparam int ENTRY_W = BITWIDTH;
`endif

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_count;
    logic [BITWIDTH-1:0] r_dout;
    logic                r_ovf;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_ovf_clr;
    logic                w_head_fe;
    logic [ENTRY_W-1:0]  w_head;
    logic [ENTRY_W-1:0]  w_entry_in;
    logic [BITWIDTH-1:0] w_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_head  = r_mem[r_rptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // when the CPU drains it at the same time.
    assign w_pop     = rRD && (rpaddr == 2'd0) && !w_empty;
    assign w_push    = rWR && (!w_full || w_pop);
    assign w_ovf_set = rWR && w_full && !w_pop;
    assign w_ovf_clr = rRD && (rpaddr == 2'd3);

`ifdef RX_FRAME_ERR_EN
    assign w_entry_in = {rFE, rdataIn};
    assign w_head_fe  = !w_empty && w_head[BITWIDTH];
`else
    logic w_unused_fe;
    assign w_entry_in  = rdataIn;
    assign w_head_fe   = 1'b0;
    assign w_unused_fe = rFE;
`endif

    // CPU read mux; an empty data read returns 0 (no write-through bypass)
    always_comb begin
        w_rd_data = '0;
        case (rpaddr)
            2'd0: w_rd_data = w_empty ? '0 : w_head[BITWIDTH-1:0];
            2'd1: w_rd_data = BITWIDTH'({w_head_fe, r_ovf, w_full, !w_empty});
            2'd2: w_rd_data = BITWIDTH'(r_count);
            default: w_rd_data = '0;
        endcase
    end

    // Storage array, no reset: contents are don't-care after reset
    always_ff @(posedge rClk) begin
        if (!rRst && w_push) begin
            r_mem[r_wptr] <= w_entry_in;
        end
    end

    // Pointers and fill count
    always_ff @(posedge rClk) begin
        if (rRst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered CPU read data, held while no read strobe
    always_ff @(posedge rClk) begin
        if (rRst) begin
            r_dout <= '0;
        end else if (rRD) begin
            r_dout <= w_rd_data;
        end
    end

    // Sticky overflow; a same-cycle overflow beats the clear request
    always_ff @(posedge rClk) begin
        if (rRst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign rdataOut = r_dout;
    assign rEMPTY   = w_empty;
    assign rFULL    = w_full;
    assign rrxrdy   = !w_empty;
    assign rOVF     = r_ovf;

endmodule

// File: tb/tb_buffer_r.sv
// tb_buffer_r: directed scenarios followed by randomized traffic, all checked
// against a queue-based model of the receive FIFO.
module tb_buffer_r;

    localparam int DEPTH = 4;

    logic       rClk = 1'b0;
    logic       rRst;
    logic       rWR;
    logic [7:0] rdataIn;
    logic       rFE;
    logic       rRD;
    logic [1:0] rpaddr;
    logic [7:0] rdataOut;
    logic       rEMPTY;
    logic       rFULL;
    logic       rrxrdy;
    logic       rOVF;

    buffer_r #(.BITWIDTH(8), .DEPTH(DEPTH), .ADDR_W(2)) dut (
        .rClk     (rClk),
        .rRst     (rRst),
        .rWR      (rWR),
        .rdataIn  (rdataIn),
        .rFE      (rFE),
        .rRD      (rRD),
        .rpaddr   (rpaddr),
        .rdataOut (rdataOut),
        .rEMPTY   (rEMPTY),
        .rFULL    (rFULL),
        .rrxrdy   (rrxrdy),
        .rOVF     (rOVF)
    );

    always #5 rClk = ~rClk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       fq[$];
    logic       m_ovf  = 1'b0;
    logic [7:0] m_dout = 8'h00;
    int         max_sz = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input string tag, input logic rst, input logic wr, input logic [7:0] din,
                        input logic fe, input logic rd, input logic [1:0] addr);
        int   sz;
        logic full, pop, set, hfe;
        rRst = rst; rWR = wr; rdataIn = din; rFE = fe; rRD = rd; rpaddr = addr;
        sz   = mq.size();
        full = (sz == DEPTH);
        pop  = rd && (addr == 2'd0) && (sz > 0);
`ifdef RX_FRAME_ERR_EN
        hfe = (sz > 0) ? fq[0] : 1'b0;
`else
        hfe = 1'b0;
`endif
        if (rst) begin
            mq.delete();
            fq.delete();
            m_ovf  = 1'b0;
            m_dout = 8'h00;
        end else begin
            if (rd) begin
                case (addr)
                    2'd0: m_dout = (sz > 0) ? mq[0] : 8'h00;
                    2'd1: m_dout = {4'h0, hfe, m_ovf, full, (sz > 0)};
                    2'd2: m_dout = 8'(sz);
                    default: m_dout = 8'h00;
                endcase
            end
            set = wr && full && !pop;
            if (set) m_ovf = 1'b1;
            else if (rd && addr == 2'd3) m_ovf = 1'b0;
            if (pop) begin
                void'(mq.pop_front());
                void'(fq.pop_front());
            end
            if (wr && (!full || pop)) begin
                mq.push_back(din);
                fq.push_back(fe);
            end
        end
        if (mq.size() > max_sz) max_sz = mq.size();
        @(posedge rClk);
        #1;
        check({tag, ".dout"},  rdataOut, m_dout);
        check({tag, ".empty"}, rEMPTY,   mq.size() == 0);
        check({tag, ".full"},  rFULL,    mq.size() == DEPTH);
        check({tag, ".rdy"},   rrxrdy,   mq.size() != 0);
        check({tag, ".ovf"},   rOVF,     m_ovf);
        rRst = 1'b0; rWR = 1'b0; rRD = 1'b0; rFE = 1'b0;
    endtask

    task automatic push(input string tag, input logic [7:0] d);
        step(tag, 1'b0, 1'b1, d, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic rd(input string tag, input logic [1:0] a);
        step(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a);
    endtask

    initial begin
        rRst = 1'b1; rWR = 1'b0; rdataIn = 8'h00; rFE = 1'b0; rRD = 1'b0; rpaddr = 2'd0;

        // Reset state
        step("rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        check("rst.empty_c", rEMPTY, 1'b1);

        // Basic push/read
        push("t1.push", 8'hA5);
        push("t1.push", 8'h3C);
        check("t1.rdy_c", rrxrdy, 1'b1);
        rd("t1.cnt", 2'd2);      check("t1.cnt_c", rdataOut, 8'h02);
        rd("t1.rd", 2'd0);       check("t1.rd0_c", rdataOut, 8'hA5);
        rd("t1.rd", 2'd0);       check("t1.rd1_c", rdataOut, 8'h3C);
        check("t1.empty_c", rEMPTY, 1'b1);

        // Overflow and clear
        push("t2.push", 8'h11); push("t2.push", 8'h22);
        push("t2.push", 8'h33); push("t2.push", 8'h44);
        push("t2.ovf", 8'h55);
        check("t2.ovf_c", rOVF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rd("t2.drain", 2'd0);
            check("t2.drain_c", rdataOut, 8'h11 * (i + 1));
        end
        rd("t2.stat", 2'd1);     check("t2.stat_c", rdataOut, 8'h04);
        rd("t2.clr", 2'd3);
        rd("t2.stat2", 2'd1);    check("t2.stat2_c", rdataOut, 8'h00);

        // Wrap-around with interleaved push/pop
        max_sz = 0;
        for (int i = 1; i <= 10; i++) begin
            push("t3.push", 8'(i));
            rd("t3.pop", 2'd0);
            check("t3.pop_c", rdataOut, 8'(i));
        end
        check("t3.maxcnt", max_sz, 1);

        // Full with simultaneous push and pop
        push("t4.fill", 8'hB1); push("t4.fill", 8'hB2);
        push("t4.fill", 8'hB3); push("t4.fill", 8'hB4);
        step("t4.pp", 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 2'd0);
        check("t4.pp_c", rdataOut, 8'hB1);
        check("t4.ovf_c", rOVF, 1'b0);
        check("t4.full_c", rFULL, 1'b1);
        for (int i = 0; i < 4; i++) rd("t4.drain", 2'd0);
        check("t4.last_c", rdataOut, 8'h99);

        // Empty: push and read in the same cycle returns 0
        step("t5.pp", 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 2'd0);
        check("t5.pp_c", rdataOut, 8'h00);
        rd("t5.rd", 2'd0);       check("t5.rd_c", rdataOut, 8'h7E);

        // Reset mid-stream
        push("t6.push", 8'hC1); push("t6.push", 8'hC2); push("t6.push", 8'hC3);
        rd("t6.cnt", 2'd2);
        step("t6.rst", 1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 2'd0);
        check("t6.dout_c", rdataOut, 8'h00);
        rd("t6.cnt2", 2'd2);     check("t6.cnt2_c", rdataOut, 8'h00);
        rd("t6.rd", 2'd0);       check("t6.rd_c", rdataOut, 8'h00);
`ifdef RX_FRAME_ERR_EN
        step("t6.fe", 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 2'd0);
        rd("t6.festat", 2'd1);   check("t6.festat_c", rdataOut, 8'h09);
        rd("t6.ferd", 2'd0);     check("t6.ferd_c", rdataOut, 8'h40);
`endif

        // Randomized traffic in phases of varying push pressure
        for (int ph = 0; ph < 6; ph++) begin
            int wr_pct = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 50 : 20);
            for (int i = 0; i < 300; i++) begin
                logic r_rst, r_wr, r_rd;
                logic [1:0] r_a;
                r_rst = ($urandom_range(0, 199) == 0);
                r_wr  = ($urandom_range(0, 99) < wr_pct);
                r_rd  = ($urandom_range(0, 99) < 50);
                r_a   = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
                step("rand", r_rst, r_wr, 8'($urandom), 1'($urandom), r_rd, r_a);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
